als_level_filter: RTL and testbench
===================================

ALS_LEVEL_FILTER -- requirements
Module: als_level_filter

Parameters
REQ-001 Parameter DARK_ON, default 8'd64: filtered level strictly below this value enters DARK.
REQ-002 Parameter DARK_OFF, default 8'd80: filtered level strictly above this value leaves DARK; DARK_ON < DARK_OFF is required.

Interface
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 value  input  16  raw PmodALS SPI frame from the upstream SPI receiver; light sample in value[12:5].
REQ-006 value_strobe  input  1  one-cycle pulse in the cycle a new value is presented.
REQ-007 level  output  8  8-sample moving average of the light field.
REQ-008 level_valid  output  1  high once 8 samples have been accepted since reset.
REQ-009 level_strobe  output  1  one-cycle pulse when level is updated while valid.
REQ-010 dark  output  1  hysteretic dark indication; high only in state DARK.

Function
REQ-011 On each value_strobe, light = value[12:5] shall be accepted; value[15:13] and value[4:0] shall be ignored.
REQ-012 The block shall hold an 8-entry circular buffer of light samples, a 3-bit write pointer and an 11-bit running sum.
REQ-013 Stage 1, at the edge ending a strobe cycle: sum <= sum - buf[wr] + light; buf[wr] <= light; wr <= wr+1 (wraps 7->0); sample count increments, saturating at 8.
REQ-014 Stage 2, at the following edge: level <= sum[10:3] (truncating divide by 8, no rounding).
REQ-015 level_strobe shall pulse for one cycle, coincident with the level update, only when count = 8 after stage 1; latency strobe -> level_strobe is 2 cycles.
REQ-016 Strobes on consecutive cycles shall each be accepted without loss; the two stages are fully pipelined.
REQ-017 No strobe: buffer, sum, pointer, level, and state shall hold.
REQ-018 FSM states: WARMUP, BRIGHT, DARK.
REQ-019 WARMUP -> DARK if the first valid level < DARK_ON, else -> BRIGHT; evaluated in the cycle of the first level_strobe.
REQ-020 BRIGHT -> DARK when level_strobe and new level < DARK_ON.
REQ-021 DARK -> BRIGHT when level_strobe and new level > DARK_OFF.
REQ-022 Levels in [DARK_ON, DARK_OFF] shall hold the current BRIGHT/DARK state.
REQ-023 dark and level_valid shall be registered and change in the same cycle as level.
REQ-024 level_valid shall be 1 in BRIGHT or DARK and 0 in WARMUP.
REQ-025 The sum shall never overflow; the maximum value is 8*255 = 2040 < 2048.

Reset
REQ-026 reset_n low shall immediately clear buffer, sum, pointer, count, level, level_valid, level_strobe, and dark to 0 and set the state to WARMUP.
REQ-027 Reset asserted mid-operation shall discard all history; after release, 8 new samples are required before level_valid returns.

Verification
REQ-028 Reset, then 8 strobes of value=16'h1000 (light 0x80) -> level_strobe only after the 8th strobe (+2 cycles), level=8'h80, level_valid=1, dark=0.
REQ-029 Continuing, strobes of 16'h0400 (light 0x20) -> levels 116,104,92,80,68,56; dark rises with level 56 (6th strobe).
REQ-030 Continuing, 8 strobes of 16'h0900 (light 0x48) -> level settles at 72, dark stays 1; then 16'h0C00 (0x60) strobes -> dark falls at the first level > 80.
REQ-031 value=16'hE01F strobed 8 times after reset -> level=0, dark=1 (garbage bits ignored); back-to-back strobes produce one level_strobe each.
REQ-032 Reset pulsed after 5 strobes, then 7 strobes -> level_valid stays 0; the 8th strobe yields the first level_strobe.

Source files
------------

// File: rtl/als_level_filter.sv
// Ambient-light level filter: 8-sample moving average of the PmodALS light field with a hysteretic dark flag.
// Two-stage pipeline (accumulate, then publish); level_strobe follows value_strobe by 2 cycles; a strobe every cycle is accepted.
module als_level_filter #(
  parameter logic [7:0] DARK_ON  = 8'd64,
  parameter logic [7:0] DARK_OFF = 8'd80
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        value_strobe,
  output logic [7:0]  level,
  output logic        level_valid,
  output logic        level_strobe,
  output logic        dark
);

  typedef enum logic [1:0] {WARMUP, BRIGHT, DARK} state_t;

  logic [7:0]  samples [8];
  logic [2:0]  wr;
  logic [10:0] sum;
  logic [3:0]  count;
  logic        s1_done;
  state_t      state;
  logic [7:0]  light;
  logic [7:0]  new_level;
  logic        unused_bits;

  assign light       = value[12:5];
  assign new_level   = sum[10:3];
  assign unused_bits = ^{value[15:13], value[4:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) samples[i] <= 8'd0;
      wr           <= 3'd0;
      sum          <= 11'd0;
      count        <= 4'd0;
      s1_done      <= 1'b0;
      level        <= 8'd0;
      level_valid  <= 1'b0;
      level_strobe <= 1'b0;
      dark         <= 1'b0;
      state        <= WARMUP;
    end else begin
      s1_done      <= value_strobe;
      level_strobe <= 1'b0;

      // Stage 1: swap the oldest sample out of the running sum.
      if (value_strobe) begin
        sum         <= sum - {3'b000, samples[wr]} + {3'b000, light};
        samples[wr] <= light;
        wr          <= wr + 3'd1;
        if (count != 4'd8) count <= count + 4'd1;
      end

      // Stage 2: count here already reflects the previous stage-1 update.
      if (s1_done) begin
        level <= new_level;
        if (count == 4'd8) begin
          level_strobe <= 1'b1;
          level_valid  <= 1'b1;
          case (state)
            WARMUP, BRIGHT: begin
              if (new_level < DARK_ON) begin
                state <= DARK;
                dark  <= 1'b1;
              end else begin
                state <= BRIGHT;
                dark  <= 1'b0;
              end
            end
            DARK: begin
              if (new_level > DARK_OFF) begin
                state <= BRIGHT;
                dark  <= 1'b0;
              end
            end
            default: begin
              state <= WARMUP;
              dark  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_als_level_filter.sv
// Directed bench for als_level_filter with hand-computed moving-average levels.
module tb_als_level_filter;

  logic        clock;
  logic        reset_n;
  logic [15:0] value;
  logic        value_strobe;
  logic [7:0]  level;
  logic        level_valid;
  logic        level_strobe;
  logic        dark;

  int checks = 0;
  int passed = 0;
  int ls_count = 0;

  als_level_filter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .value       (value),
    .value_strobe(value_strobe),
    .level       (level),
    .level_valid (level_valid),
    .level_strobe(level_strobe),
    .dark        (dark)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (level_strobe) ls_count <= ls_count + 1;

  task automatic strobe(input logic [15:0] v);
    @(posedge clock); #1;
    value = v;
    value_strobe = 1'b1;
    @(posedge clock); #1;
    value_strobe = 1'b0;
  endtask

  task automatic burst(input logic [15:0] v, input int n);
    @(posedge clock); #1;
    value = v;
    value_strobe = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    value_strobe = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    value = 16'h0;
    value_strobe = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({level, level_valid, level_strobe, dark} !== 11'd0)
      $display("FAIL reset_outputs got %h exp 0", {level, level_valid, level_strobe, dark});
    else passed++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_warmup();
    int base;
    base = ls_count;
    for (int i = 0; i < 7; i++) strobe(16'h1000);
    settle();
    checks++;
    if (ls_count - base !== 0 || level_valid !== 1'b0)
      $display("FAIL warmup_7 got strobes=%0d valid=%b exp 0 0", ls_count - base, level_valid);
    else passed++;
    strobe(16'h1000);
    @(negedge clock);
    checks++;
    if (level_strobe !== 1'b0)
      $display("FAIL latency_early got %b exp 0", level_strobe);
    else passed++;
    @(negedge clock);
    checks++;
    if (level_strobe !== 1'b1)
      $display("FAIL latency_2 got %b exp 1", level_strobe);
    else passed++;
    checks++;
    if (level !== 8'h80 || level_valid !== 1'b1 || dark !== 1'b0)
      $display("FAIL first_level got %h v=%b d=%b exp 80 1 0", level, level_valid, dark);
    else passed++;
    repeat (5) @(negedge clock);
    checks++;
    if (level !== 8'h80 || level_strobe !== 1'b0 || ls_count - base !== 1)
      $display("FAIL idle_hold got %h s=%b n=%0d exp 80 0 1", level, level_strobe, ls_count - base);
    else passed++;
  endtask

  task automatic test_descend();
    logic [7:0] exp_lvl [6] = '{8'd116, 8'd104, 8'd92, 8'd80, 8'd68, 8'd56};
    logic       exp_dk  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      strobe(16'h0400);
      settle();
      checks++;
      if (level !== exp_lvl[i] || dark !== exp_dk[i])
        $display("FAIL descend_%0d got %0d d=%b exp %0d d=%b", i, level, dark, exp_lvl[i], exp_dk[i]);
      else passed++;
    end
  endtask

  task automatic test_hysteresis();
    logic [7:0] exp_a [8] = '{8'd49, 8'd42, 8'd47, 8'd52, 8'd57, 8'd62, 8'd67, 8'd72};
    logic [7:0] exp_b [3] = '{8'd75, 8'd78, 8'd81};
    logic       exp_bd[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      strobe(16'h0900);
      settle();
      checks++;
      if (level !== exp_a[i] || dark !== 1'b1)
        $display("FAIL hold_dark_%0d got %0d d=%b exp %0d d=1", i, level, dark, exp_a[i]);
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      strobe(16'h0C00);
      settle();
      checks++;
      if (level !== exp_b[i] || dark !== exp_bd[i])
        $display("FAIL rise_%0d got %0d d=%b exp %0d d=%b", i, level, dark, exp_b[i], exp_bd[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int base;
    pulse_reset();
    #1;
    checks++;
    if (level_valid !== 1'b0 || dark !== 1'b0 || level !== 8'd0)
      $display("FAIL reset_mid got v=%b d=%b l=%0d exp 0 0 0", level_valid, dark, level);
    else passed++;
    base = ls_count;
    burst(16'hE01F, 8);
    settle();
    checks++;
    if (level !== 8'd0 || dark !== 1'b1 || level_valid !== 1'b1 || ls_count - base !== 1)
      $display("FAIL garbage got l=%0d d=%b v=%b n=%0d exp 0 1 1 1", level, dark, level_valid, ls_count - base);
    else passed++;
    burst(16'h1FE0, 3);
    settle();
    checks++;
    // three 0xFF samples replace zeros: 765/8 = 95
    if (level !== 8'd95 || dark !== 1'b0 || ls_count - base !== 4)
      $display("FAIL b2b got l=%0d d=%b n=%0d exp 95 0 4", level, dark, ls_count - base);
    else passed++;
  endtask

  task automatic test_reset_history();
    int base;
    pulse_reset();
    for (int i = 0; i < 5; i++) strobe(16'h1000);
    pulse_reset();
    base = ls_count;
    for (int i = 0; i < 7; i++) strobe(16'h1000);
    settle();
    checks++;
    if (level_valid !== 1'b0 || ls_count - base !== 0)
      $display("FAIL history_7 got v=%b n=%0d exp 0 0", level_valid, ls_count - base);
    else passed++;
    strobe(16'h1000);
    settle();
    checks++;
    if (level_valid !== 1'b1 || ls_count - base !== 1 || level !== 8'h80 || dark !== 1'b0)
      $display("FAIL history_8 got v=%b n=%0d l=%h d=%b exp 1 1 80 0", level_valid, ls_count - base, level, dark);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_descend();
    test_hysteresis();
    test_back_to_back();
    test_reset_history();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
